// File: rtl/credit_controller.sv
// credit_controller: coin credit counter, start grant and blink-gated credit display sequencer
// Ports: clk, resetN (async active-low); coinIn/startIn debounced levels (rising edge = event);
// gameOver, startOfFrame 1-cycle pulses; credits 0..MAX_CREDITS; creditVisible display gate;
// gameStart 1-cycle grant pulse; inGame high while a game runs.
module credit_controller #(
  parameter int MAX_CREDITS  = 9,
  parameter int BLINK_FRAMES = 60,
  parameter int BLINK_HALF   = 8
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       coinIn,
  input  logic       startIn,
  input  logic       gameOver,
  input  logic       startOfFrame,
  output logic [3:0] credits,
  output logic       creditVisible,
  output logic       gameStart,
  output logic       inGame
);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam int HW = $clog2(BLINK_HALF + 1);
  typedef enum logic [1:0] {IDLE, BLINK, GAME} state_t;
  state_t state;
  logic coinQ, coinD, startQ, startD;
  logic [FW-1:0] frameCnt;
  logic [HW-1:0] halfCnt;
  logic coinRise, startRise, grant;
  logic [4:0] sum;
  logic [3:0] credNext;
  // Inputs are sampled first, so edges act 2 clk after the level rises.
  // A simultaneous coin and grant nets to zero, even at saturation.
  always_comb begin
    coinRise  = coinQ & ~coinD;
    startRise = startQ & ~startD;
    grant     = startRise && state != GAME && credits != 4'd0;
    sum       = 5'(credits) + 5'(coinRise) - 5'(grant);
    credNext  = sum > 5'(MAX_CREDITS) ? 4'(MAX_CREDITS) : sum[3:0];
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state         <= IDLE;
      coinQ         <= 1'b0;
      coinD         <= 1'b0;
      startQ        <= 1'b0;
      startD        <= 1'b0;
      frameCnt      <= '0;
      halfCnt       <= '0;
      credits       <= 4'd0;
      creditVisible <= 1'b1;
      gameStart     <= 1'b0;
      inGame        <= 1'b0;
    end else begin
      coinQ     <= coinIn;
      coinD     <= coinQ;
      startQ    <= startIn;
      startD    <= startQ;
      credits   <= credNext;
      gameStart <= grant;
      if (grant) begin
        state         <= GAME;
        inGame        <= 1'b1;
        creditVisible <= 1'b1;
      end else if (state == GAME) begin
        if (gameOver) begin
          state  <= IDLE;
          inGame <= 1'b0;
        end
      end else if (coinRise) begin
        state         <= BLINK;
        frameCnt      <= '0;
        halfCnt       <= '0;
        creditVisible <= 1'b0;
      end else if (state == BLINK && startOfFrame) begin
        if (frameCnt == FW'(BLINK_FRAMES - 1)) begin
          state         <= IDLE;
          creditVisible <= 1'b1;
        end else begin
          frameCnt      <= frameCnt + 1'b1;
          halfCnt       <= halfCnt == HW'(BLINK_HALF - 1) ? '0 : halfCnt + 1'b1;
          creditVisible <= halfCnt == HW'(BLINK_HALF - 1) ? ~creditVisible : creditVisible;
        end
      end
    end
  end
endmodule

// File: tb/tb_credit_controller.sv
// tb_credit_controller: scoreboard bench for credit_controller
module tb_credit_controller;
  logic clk, resetN, coinIn, startIn, gameOver, startOfFrame;
  logic [3:0] credits;
  logic creditVisible, gameStart, inGame;
  typedef struct {
    string name;
    int    cr;
    bit    vis;
    bit    ig;
    int    gs;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int gsCount = 0;
  bit gsPrev = 0;

  credit_controller dut (
    .clk(clk), .resetN(resetN), .coinIn(coinIn), .startIn(startIn),
    .gameOver(gameOver), .startOfFrame(startOfFrame), .credits(credits),
    .creditVisible(creditVisible), .gameStart(gameStart), .inGame(inGame)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (gameStart) begin
        gsCount++;
        checks++;
        if (gsPrev) begin
          failures++;
          $display("FAIL gs_width gameStart high %0d consecutive cycles, required 1", 2);
        end
      end
      gsPrev = gameStart;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (credits !== 4'(e.cr) || creditVisible !== e.vis || inGame !== e.ig || gsCount != e.gs) begin
          failures++;
          $display("FAIL %s got credits=%0d vis=%b inGame=%b starts=%0d, required credits=%0d vis=%b inGame=%b starts=%0d",
                   e.name, credits, creditVisible, inGame, gsCount, e.cr, e.vis, e.ig, e.gs);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_(input string name, input int cr, input bit vis, input bit ig, input int gs);
    exp_t e;
    e.name = name; e.cr = cr; e.vis = vis; e.ig = ig; e.gs = gs;
    q.push_back(e);
    tick(1);
  endtask

  task automatic pulse(input bit c, input bit s, input bit g, input bit f);
    coinIn = c; startIn = s; gameOver = g; startOfFrame = f;
    tick(1);
    coinIn = 0; startIn = 0; gameOver = 0; startOfFrame = 0;
    tick(1);
  endtask

  task automatic doReset(input string name, input int gs);
    resetN = 0;
    #2;
    expect_(name, 0, 1, 0, gs);
    tick(1);
    resetN = 1;
    tick(1);
  endtask

  initial begin
    resetN = 0; coinIn = 0; startIn = 0; gameOver = 0; startOfFrame = 0;
    #2;
    expect_("reset", 0, 1, 0, 0);
    resetN = 1;
    tick(1);
    // T1
    repeat (3) pulse(1, 0, 0, 0);
    expect_("t1_three_coins", 3, 0, 0, 0);
    // T2
    doReset("t2_reset", 0);
    pulse(0, 1, 0, 0);
    expect_("t2_start_no_credit", 0, 1, 0, 0);
    // T3
    repeat (2) pulse(1, 0, 0, 0);
    expect_("t3_two_coins", 2, 0, 0, 0);
    pulse(0, 1, 0, 0);
    expect_("t3_grant", 1, 1, 1, 1);
    pulse(0, 1, 0, 0);
    expect_("t3_start_in_game", 1, 1, 1, 1);
    pulse(0, 0, 1, 0);
    expect_("t3_game_over", 1, 1, 0, 1);
    pulse(0, 0, 1, 0);
    expect_("t3_game_over_idle", 1, 1, 0, 1);
    // T4
    for (int i = 1; i <= 12; i++) begin
      pulse(1, 0, 0, 0);
      expect_($sformatf("t4_coin%0d", i), (1 + i > 9) ? 9 : 1 + i, 0, 0, 1);
    end
    // T5
    doReset("t5_reset", 1);
    pulse(1, 0, 0, 0);
    pulse(1, 1, 0, 0);
    expect_("t5_coin_and_grant", 1, 1, 1, 2);
    pulse(0, 0, 1, 0);
    pulse(0, 1, 0, 0);
    expect_("t5_spend_last", 0, 1, 1, 3);
    pulse(0, 0, 1, 0);
    expect_("t5_idle_empty", 0, 1, 0, 3);
    pulse(1, 1, 0, 0);
    expect_("t5_coin_start_empty", 1, 0, 0, 3);
    // T6
    doReset("t6_reset", 3);
    pulse(1, 0, 0, 0);
    for (int k = 1; k <= 60; k++) begin
      pulse(0, 0, 0, 1);
      expect_($sformatf("t6_frame%0d", k), 1, (k == 60) ? 1'b1 : 1'(((k / 8) % 2)), 0, 3);
    end
    pulse(0, 0, 0, 1);
    expect_("t6_idle_frame", 1, 1, 0, 3);
    pulse(1, 0, 0, 0);
    repeat (3) pulse(0, 0, 0, 1);
    expect_("t6_mid_blink", 2, 0, 0, 3);
    doReset("t6_async_reset", 3);
    for (int i = 0; i < 100 && q.size() > 0; i++) tick(1);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain %0d checks left pending, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
